// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART register map, bit positions and receiver FSM encoding
package uart_pkg;

   localparam logic [4:0] ADDR_CSR   = 5'h00;
   localparam logic [4:0] ADDR_DIV   = 5'h04;
   localparam logic [4:0] ADDR_FSTAT = 5'h08;
   localparam logic [4:0] ADDR_TX    = 5'h0c;
   localparam logic [4:0] ADDR_RX    = 5'h10;

   localparam int CSR_EN     = 0;
   localparam int CSR_RXIE   = 1;
   localparam int CSR_FLUSH  = 2;
   localparam int CSR_PAREN  = 3;
   localparam int CSR_PARODD = 4;

   localparam int FSTAT_EMPTY = 16;
   localparam int FSTAT_FULL  = 17;
   localparam int FSTAT_OVF   = 24;
   localparam int FSTAT_FERR  = 25;
   localparam int FSTAT_PERR  = 26;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8-bit synchronous receive FIFO with push, pop and flush
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | pop) & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign level = wr_ptr - rd_ptr;
   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (wr_ptr == rd_ptr);
   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_apb.sv
// rtl/uart_rx_apb.sv - 8N1 UART receiver with APB3 register port
// Optional parity checking is enabled with the UART_RX_PARITY_EN macro.
module uart_rx_apb
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        apbs_psel,
   input  logic        apbs_penable,
   input  logic        apbs_pwrite,
   input  logic [15:0] apbs_paddr,
   input  logic [31:0] apbs_pwdata,
   output logic [31:0] apbs_prdata,
   output logic        apbs_pready,
   output logic        apbs_pslverr,
   input  logic        rx,
   output logic        rts,
   output logic        irq,
   output logic        dreq
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [4:0]       addr;
   logic             wr_en, rd_en;
   logic             csr_wr, div_wr, fstat_wr, pop_req, flush;
   logic             en_q, rxie_q;
   logic             paren_q, parodd_q;
   logic [DIV_W-1:0] div_q, div_m1;
   logic             div_small;
   logic             ovf_q, ferr_q, perr_q;
   logic             ovf_set, ferr_set, perr_set;
   logic             rx_meta, rx_sync, rx_prev, fall;
   rx_state_e        state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             par_bad_q, par_bad_d;
   logic             sample, push_req;
   logic [7:0]       head;
   logic [LW-1:0]    level;
   logic             full, empty;
   logic             unused_bits;

   assign addr     = apbs_paddr[4:0] & 5'h1c;
   assign wr_en    = apbs_psel & apbs_penable & apbs_pwrite;
   assign rd_en    = apbs_psel & apbs_penable & ~apbs_pwrite;
   assign csr_wr   = wr_en & (addr == ADDR_CSR);
   assign div_wr   = wr_en & (addr == ADDR_DIV);
   assign fstat_wr = wr_en & (addr == ADDR_FSTAT);
   assign pop_req  = rd_en & (addr == ADDR_RX);
   assign flush    = csr_wr & apbs_pwdata[CSR_FLUSH];

   assign apbs_pready  = 1'b1;
   assign apbs_pslverr = 1'b0;
   assign unused_bits  = ^{apbs_paddr[15:5], apbs_pwdata};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall      = rx_prev & ~rx_sync;
   assign div_m1    = div_q - DIV_W'(1);
   assign div_small = (div_q < DIV_W'(2));
   assign sample    = (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= 1'b0;
         rxie_q <= 1'b0;
         div_q  <= DIV_W'(16);
      end else begin
         if (csr_wr) begin
            en_q   <= apbs_pwdata[CSR_EN];
            rxie_q <= apbs_pwdata[CSR_RXIE];
         end
         if (div_wr) div_q <= apbs_pwdata[DIV_W-1:0];
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         paren_q  <= 1'b0;
         parodd_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         if (csr_wr) begin
            paren_q  <= apbs_pwdata[CSR_PAREN];
            parodd_q <= apbs_pwdata[CSR_PARODD];
         end
         perr_q <= perr_set | (perr_q & ~(fstat_wr & apbs_pwdata[FSTAT_PERR]));
      end
   end
`else
   assign paren_q  = 1'b0;
   assign parodd_q = 1'b0;
   assign perr_q   = 1'b0;
`endif

   // A flag being set in the same cycle as its W1C keeps the set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_set  | (ovf_q  & ~(fstat_wr & apbs_pwdata[FSTAT_OVF]));
         ferr_q <= ferr_set | (ferr_q & ~(fstat_wr & apbs_pwdata[FSTAT_FERR]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         par_bad_q <= par_bad_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      par_bad_d = par_bad_q;
      push_req  = 1'b0;
      ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set  = 1'b0;
`endif
      // Disabling or an invalid divider abandons any frame in progress.
      if (!en_q || div_small) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  cnt_d   = div_q >> 1;
                  state_d = ST_START;
               end
            end
            ST_START: begin
               if (!sample) begin
                  cnt_d = cnt_q - DIV_W'(1);
               end else if (rx_sync) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d     = div_m1;
                  bit_d     = 3'd0;
                  par_bad_d = 1'b0;
                  state_d   = ST_DATA;
               end
            end
            ST_DATA: begin
               if (!sample) begin
                  cnt_d = cnt_q - DIV_W'(1);
               end else begin
                  shreg_d = {rx_sync, shreg_q[7:1]};
                  cnt_d   = div_m1;
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = paren_q ? ST_PARITY : ST_STOP;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (!sample) begin
                  cnt_d = cnt_q - DIV_W'(1);
               end else begin
                  par_bad_d = ((^shreg_q) ^ rx_sync) != parodd_q;
                  perr_set  = par_bad_d;
                  cnt_d     = div_m1;
                  state_d   = ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (!sample) begin
                  cnt_d = cnt_q - DIV_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  if (!rx_sync)        ferr_set = 1'b1;
                  else if (!par_bad_q) push_req = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign perr_set = 1'b0;
`endif

   assign ovf_set = push_req & full & ~pop_req & ~flush;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .pop   (pop_req),
      .flush (flush),
      .wdata (shreg_q),
      .rdata (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      apbs_prdata = '0;
      case (addr)
         ADDR_CSR: begin
            apbs_prdata[CSR_EN]     = en_q;
            apbs_prdata[CSR_RXIE]   = rxie_q;
            apbs_prdata[CSR_PAREN]  = paren_q;
            apbs_prdata[CSR_PARODD] = parodd_q;
         end
         ADDR_DIV: apbs_prdata[DIV_W-1:0] = div_q;
         ADDR_FSTAT: begin
            apbs_prdata[7:0]         = 8'(level);
            apbs_prdata[FSTAT_EMPTY] = empty;
            apbs_prdata[FSTAT_FULL]  = full;
            apbs_prdata[FSTAT_OVF]   = ovf_q;
            apbs_prdata[FSTAT_FERR]  = ferr_q;
            apbs_prdata[FSTAT_PERR]  = perr_q;
         end
         ADDR_RX:  if (!empty) apbs_prdata[7:0] = head;
         ADDR_TX:  apbs_prdata = '0;
         default:  apbs_prdata = '0;
      endcase
   end

   assign irq  = rxie_q & (~empty | ovf_q | ferr_q | perr_q);
   assign rts  = ~en_q | full;
   assign dreq = ~empty;

endmodule

// File: tb/tb_uart_rx_apb.sv
// tb/tb_uart_rx_apb.sv - directed self-checking bench for uart_rx_apb
module tb_uart_rx_apb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [15:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        rx = 1'b1;
   logic        rts, irq, dreq;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   uart_rx_apb #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .apbs_psel    (psel),
      .apbs_penable (penable),
      .apbs_pwrite  (pwrite),
      .apbs_paddr   (paddr),
      .apbs_pwdata  (pwdata),
      .apbs_prdata  (prdata),
      .apbs_pready  (pready),
      .apbs_pslverr (pslverr),
      .rx           (rx),
      .rts          (rts),
      .irq          (irq),
      .dreq         (dreq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // All bus and serial tasks start and end 1 time unit after a rising edge.
   task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk); d = prdata;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [15:0] a, input logic [31:0] exp);
      logic [31:0] v;
      apb_read(a, v);
      check(tag, v, exp);
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic use_par, input logic par);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      if (use_par) bit_time(par);
      bit_time(stop);
      rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] b;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rts", {31'b0, rts}, 32'd1);
      check("reset_irq", {31'b0, irq}, 32'd0);
      check("reset_dreq", {31'b0, dreq}, 32'd0);
      check("pready", {31'b0, pready}, 32'd1);
      check("pslverr", {31'b0, pslverr}, 32'd0);
      check("reset_prdata", prdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_reg("reset_div", 16'h0004, 32'd16);
      check_reg("reset_fstat", 16'h0008, 32'h0001_0000);
      check_reg("reset_csr", 16'h0000, 32'd0);

      apb_write(16'h0000, 32'h1);
      check("en_rts", {31'b0, rts}, 32'd0);
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      check("f55_dreq", {31'b0, dreq}, 32'd1);
      check_reg("f55_fstat", 16'h0008, 32'h0000_0001);
      check_reg("f55_rx", 16'h0010, 32'h55);
      check_reg("f55_fstat_after", 16'h0008, 32'h0001_0000);
      check("f55_dreq_after", {31'b0, dreq}, 32'd0);
      check_reg("empty_rx", 16'h0010, 32'h0);

      for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      check_reg("ovf_fstat", 16'h0008, 32'h0102_0008);
      check("ovf_rts", {31'b0, rts}, 32'd1);
      for (int i = 0; i < 8; i++) check_reg($sformatf("ovf_rx%0d", i), 16'h0010, 32'(i));
      check_reg("ovf_drained", 16'h0008, 32'h0101_0000);
      apb_write(16'h0008, 32'h0100_0000);
      check_reg("ovf_w1c", 16'h0008, 32'h0001_0000);
      check("ovf_rts_after", {31'b0, rts}, 32'd0);

      apb_write(16'h0000, 32'h3);
      check("ferr_irq_before", {31'b0, irq}, 32'd0);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      check_reg("ferr_fstat", 16'h0008, 32'h0201_0000);
      check("ferr_irq", {31'b0, irq}, 32'd1);
      apb_write(16'h0008, 32'h0200_0000);
      check("ferr_irq_w1c", {31'b0, irq}, 32'd0);
      check_reg("ferr_w1c", 16'h0008, 32'h0001_0000);

      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check_reg("glitch_fstat", 16'h0008, 32'h0001_0000);

      b = 8'h3C;
      bit_time(1'b0);
      for (int i = 0; i < 3; i++) bit_time(b[i]);
      rx = b[3];
      apb_write(16'h0000, 32'h0);
      repeat (14) @(posedge clk);
      #1;
      for (int i = 4; i < 8; i++) bit_time(b[i]);
      bit_time(1'b1);
      check_reg("abort_fstat", 16'h0008, 32'h0001_0000);
      check("abort_rts", {31'b0, rts}, 32'd1);
      apb_write(16'h0000, 32'h1);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      check_reg("abort_next_rx", 16'h0010, 32'h3C);

      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      check_reg("flush_pre", 16'h0008, 32'h0000_0002);
      apb_write(16'h0000, 32'h5);
      check_reg("flush_fstat", 16'h0008, 32'h0001_0000);
      check_reg("flush_csr", 16'h0000, 32'h1);

      apb_write(16'h000C, 32'hFF);
      check_reg("tx_read", 16'h000C, 32'h0);
      check_reg("unmapped_14", 16'h0014, 32'h0);
      check_reg("alias_div", 16'h0024, 32'd16);

`ifdef UART_RX_PARITY_EN
      apb_write(16'h0000, 32'h9);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      check_reg("perr_fstat", 16'h0008, 32'h0401_0000);
      apb_write(16'h0008, 32'h0400_0000);
      check_reg("perr_w1c", 16'h0008, 32'h0001_0000);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      check_reg("par_ok_fstat", 16'h0008, 32'h0000_0001);
      check_reg("par_ok_rx", 16'h0010, 32'h07);
`else
      apb_write(16'h0000, 32'h19);
      check_reg("nopar_csr", 16'h0000, 32'h1);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      check_reg("nopar_rx", 16'h0010, 32'h07);
`endif

      apb_write(16'h0000, 32'h3);
      send_frame(8'h99, 1'b1, 1'b0, 1'b0);
      check("mid_irq_pre", {31'b0, irq}, 32'd1);
      check("mid_dreq_pre", {31'b0, dreq}, 32'd1);
      rx = 1'b0;
      repeat (40) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_rts", {31'b0, rts}, 32'd1);
      check("mid_rst_irq", {31'b0, irq}, 32'd0);
      check("mid_rst_dreq", {31'b0, dreq}, 32'd0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check_reg("mid_rst_div", 16'h0004, 32'd16);
      check_reg("mid_rst_fstat", 16'h0008, 32'h0001_0000);
      check_reg("mid_rst_csr", 16'h0000, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
